// File: rtl/ascii_digit_scanner.sv
// ascii_digit_scanner: time-multiplexes one ASCII 7-segment decoder across
// four common-anode digits. Holds a 4-entry character buffer written by the
// host, scans the digits at SCAN_DIV cycles per slot, and opens each slot
// with BLANK_CYC cycles of all-anodes-off so the decoder settles on the new
// character before its anode turns on.
module ascii_digit_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [6:0] ascii_out,
  output logic       dp_out,
  output logic [3:0] an_n,
  output logic       frame_start
);

  localparam int               CNT_W      = 20;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       SPACE      = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [7:0]       char_buf [4];
  logic [7:0]       cur_char;
  logic [3:0]       an_next;
  logic [6:0]       ascii_next;
  logic             dp_next;
  logic             fs_next;

  // Character buffer: host writes land on the edge, acknowledged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        char_buf[i] <= SPACE;
      end
      wr_ack <= 1'b0;
    end else begin
      if (wr_en) begin
        char_buf[wr_addr] <= wr_data;
      end
      wr_ack <= wr_en;
    end
  end

  // Scan state register: FSM state, position within the slot, and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: en low always wins, otherwise walk BLANK -> SHOW -> next digit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = 2'd0;
        if (en) begin
          state_next = BLANK;
        end
      end
      BLANK: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = 2'd0;
        end else if (cnt == BLANK_LAST) begin
          state_next = SHOW;
          cnt_next   = cnt + 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = 2'd0;
        end else if (cnt == SLOT_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Output decode from the upcoming state, so outputs are registered yet
  // line up with the state they describe; the buffer read sees pre-write data.
  always_comb begin
    cur_char   = char_buf[idx_next];
    an_next    = 4'b1111;
    ascii_next = SPACE[6:0];
    dp_next    = 1'b0;
    fs_next    = 1'b0;
    if (state_next != IDLE) begin
      ascii_next = cur_char[6:0];
      dp_next    = cur_char[7];
    end
    if (state_next == SHOW) begin
      an_next = ~(4'b0001 << idx_next);
    end
    if (state_next == BLANK && cnt_next == '0 && idx_next == 2'd0) begin
      fs_next = 1'b1;
    end
  end

  // Display output registers: glitch-free anode drive and decoder inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n        <= 4'b1111;
      ascii_out   <= SPACE[6:0];
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an_n        <= an_next;
      ascii_out   <= ascii_next;
      dp_out      <= dp_next;
      frame_start <= fs_next;
    end
  end

endmodule

// File: tb/tb_ascii_digit_scanner.sv
// tb_ascii_digit_scanner: cycle-by-cycle scoreboard against a frame-position
// model, plus table-driven digit checks and hand-written corner sequences.
module tb_ascii_digit_scanner;

  localparam int SD = 10;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [6:0] ascii_out;
  logic       dp_out;
  logic [3:0] an_n;
  logic       frame_start;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ascii;
    logic       dp;
    logic       ack;
    logic       fs;
  } outs_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic [3:0] exp_an;
    logic [6:0] exp_ascii;
    logic       exp_dp;
  } vec_t;

  localparam outs_t IDLE_OUT = '{an: 4'hF, ascii: 7'h20, dp: 1'b0, ack: 1'b0, fs: 1'b0};

  outs_t      exp_q[$];
  int         n_compared = 0;
  int         n_mismatched = 0;
  bit         m_on;
  int         m_t;
  logic [7:0] m_buf [4];
  vec_t       tbl [4];

  ascii_digit_scanner #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .ascii_out  (ascii_out),
    .dp_out     (dp_out),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  function automatic outs_t actual();
    outs_t o;
    o = '{an: an_n, ascii: ascii_out, dp: dp_out, ack: wr_ack, fs: frame_start};
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t got, input outs_t want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: got an_n=%b ascii=%h dp=%b ack=%b fs=%b, required an_n=%b ascii=%h dp=%b ack=%b fs=%b",
               name, $time, got.an, got.ascii, got.dp, got.ack, got.fs,
               want.an, want.ascii, want.dp, want.ack, want.fs);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    n_compared++;
    if (got != want) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: got %0h, required %0h", name, $time, got, want);
    end
  endtask

  // Reference model: position within the 4*SD-cycle frame since enable.
  task automatic modelStep(output outs_t e);
    int digit;
    int ph;
    e = IDLE_OUT;
    if (!rst_n) begin
      m_on = 1'b0;
      m_t  = 0;
      for (int i = 0; i < 4; i++) m_buf[i] = 8'h20;
      return;
    end
    e.ack = wr_en;
    if (!en) m_on = 1'b0;
    else if (!m_on) begin
      m_on = 1'b1;
      m_t  = 0;
    end else m_t = (m_t + 1) % (4 * SD);
    if (m_on) begin
      digit   = m_t / SD;
      ph      = m_t % SD;
      e.an    = (ph < BC) ? 4'hF : ~(4'b0001 << digit);
      e.ascii = m_buf[digit][6:0];
      e.dp    = m_buf[digit][7];
      e.fs    = (m_t == 0);
    end
    if (wr_en) m_buf[wr_addr] = wr_data;
  endtask

  task automatic applyStimulus(input logic r, input logic e_in, input logic we,
                               input logic [1:0] a, input logic [7:0] d);
    outs_t e;
    rst_n   = r;
    en      = e_in;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    modelStep(e);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    outs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkValue("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("cycle", actual(), e);
    end
  endtask

  task automatic step(input logic r, input logic e_in, input logic we,
                      input logic [1:0] a, input logic [7:0] d);
    applyStimulus(r, e_in, we, a, d);
    tick();
  endtask

  task automatic waitAnode(input logic [3:0] target, input string name);
    int n = 0;
    while (an_n !== target && n < 4 * SD + 5) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
      n++;
    end
    if (an_n !== target) checkValue(name, int'(an_n), int'(target));
  endtask

  task automatic waitFs(input string name);
    int n = 0;
    while (frame_start !== 1'b1 && n < 4 * SD + 5) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
      n++;
    end
    if (frame_start !== 1'b1) checkValue(name, int'(frame_start), 1);
  endtask

  initial begin
    int n;
    outs_t e;

    tbl[0] = '{addr: 2'd0, data: 8'h41, exp_an: 4'b1110, exp_ascii: 7'h41, exp_dp: 1'b0};
    tbl[1] = '{addr: 2'd1, data: 8'h42, exp_an: 4'b1101, exp_ascii: 7'h42, exp_dp: 1'b0};
    tbl[2] = '{addr: 2'd2, data: 8'h43, exp_an: 4'b1011, exp_ascii: 7'h43, exp_dp: 1'b0};
    tbl[3] = '{addr: 2'd3, data: 8'h44, exp_an: 4'b0111, exp_ascii: 7'h44, exp_dp: 1'b0};

    // Reset asserted before any clock edge
    rst_n = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_initial", actual(), IDLE_OUT);

    // Hold reset with random inputs
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    // Enable with no writes: every digit shows a space
    $display("[TB] default buffer scan");
    for (int i = 0; i < 4; i++) begin
      waitAnode(tbl[i].exp_an, "default_anode");
      checkValue("default_ascii", int'(ascii_out), 'h20);
    end
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

    // Scan sequence: write ABCD while dark, then enable
    $display("[TB] scan sequence ABCD");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, tbl[i].addr, tbl[i].data);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      waitAnode(tbl[i].exp_an, "scan_anode");
      checkValue("scan_ascii", int'(ascii_out), int'(tbl[i].exp_ascii));
      checkValue("scan_dp", int'(dp_out), int'(tbl[i].exp_dp));
    end

    // Frame period
    waitFs("fs_first");
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    checkValue("frame_period", n, 4 * SD);

    // Decimal point and single-cycle acknowledge
    $display("[TB] decimal point and ack");
    step(1'b1, 1'b1, 1'b1, 2'd2, 8'hB1);
    checkValue("ack_high", int'(wr_ack), 1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    checkValue("ack_low", int'(wr_ack), 0);
    waitAnode(4'b1011, "dp_anode");
    checkValue("dp_ascii", int'(ascii_out), 'h31);
    checkValue("dp_on", int'(dp_out), 1);

    // Live update of the digit being shown
    $display("[TB] live update");
    waitFs("fs_live");
    waitAnode(4'b1101, "live_wait");
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 2'd1, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    checkValue("live_ascii", int'(ascii_out), 'h5A);
    checkValue("live_anode", int'(an_n), 'b1101);

    // Disable mid-SHOW and resume
    $display("[TB] disable and resume");
    waitFs("fs_dis");
    waitAnode(4'b1101, "dis_wait");
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    checkValue("dis_anode", int'(an_n), 'hF);
    checkValue("dis_ascii", int'(ascii_out), 'h20);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    checkValue("resume_fs", int'(frame_start), 1);
    n = 1;
    while (an_n === 4'hF && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
      n++;
    end
    checkValue("resume_latency", n, 1 + BC);
    checkValue("resume_anode", int'(an_n), 'b1110);

    // Asynchronous reset between edges during SHOW
    $display("[TB] async reset mid-frame");
    waitAnode(4'b1110, "ar_wait");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    #3 rst_n = 1'b0;
    #1 checkOutput("async_reset", actual(), IDLE_OUT);
    exp_q.delete();
    modelStep(e);
    exp_q.push_back(e);
    tick();
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    checkValue("ar_restart_fs", int'(frame_start), 1);
    for (int i = 0; i < 4; i++) begin
      waitAnode(tbl[i].exp_an, "ar_anode");
      checkValue("ar_ascii", int'(ascii_out), 'h20);
      checkValue("ar_dp", int'(dp_out), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ascii_digit_scanner.md
# ascii_digit_scanner

Time-multiplexing controller that shares one ASCII-to-7-segment common-anode decoder among four display digits. It holds a 4-entry character buffer written by the host, sequences the digits at a programmable scan rate, and drives active-low anode enables with a blanking gap between digits to suppress ghosting. It sits between the host logic and the existing single-digit ASCII decoder: `ascii_out` and `dp_out` feed the decoder's ASCII and dp inputs, and `an_n` drives the digit transistors.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz). Legal range: `BLANK_CYC+1` to 2^20-1.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off. Legal range: 1 to `SCAN_DIV-1`.
- `clk`  in  1  system clock, 50 MHz; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  scan enable; low forces the display dark.
- `wr_en`  in  1  write strobe for the character buffer.
- `wr_addr`  in  2  digit index, 0 = rightmost digit.
- `wr_data`  in  8  bit 7 = decimal point, bits 6:0 = ASCII code.
- `wr_ack`  out  1  one-cycle pulse confirming a write.
- `ascii_out`  out  7  ASCII code for the decoder.
- `dp_out`  out  1  decimal point for the decoder, active high.
- `an_n`  out  4  anode enables, active low, one-hot-low or all ones.
- `frame_start`  out  1  one-cycle pulse at the start of digit 0's slot.

## Operation
- Buffer: 4 entries × 8 bits. Reset value of every entry is 8'h20 (space, dp off).
- Every write is accepted; there is no backpressure.
- On a `wr_en` edge, `buf[wr_addr]` is set to `wr_data`, and `wr_ack` is 1 on the following cycle.
- Back-to-back writes are legal, one per cycle. Each write produces its own `wr_ack` pulse.
- FSM states:
  - IDLE: `an_n` = 4'b1111, `ascii_out` = 7'h20, `dp_out` = 0; the slot counter and digit index are held at 0.
  - BLANK: `an_n` = 4'b1111; `ascii_out` and `dp_out` already present the current digit, so the decoder settles before the anode turns on.
  - SHOW: `an_n[idx]` = 0, all other bits 1.
- Transitions:
  - IDLE to BLANK (idx = 0) on an edge with `en` = 1. `frame_start` pulses in that first BLANK cycle.
  - BLANK to SHOW after `BLANK_CYC` cycles.
  - SHOW to BLANK after `SCAN_DIV - BLANK_CYC` cycles. At the same time idx increments and wraps from 3 to 0; `frame_start` pulses on the wrap.
  - Any state to IDLE on an edge with `en` = 0. `en` takes priority over counter expiry.
- `ascii_out` and `dp_out` are registered from `buf[idx]` every cycle in BLANK and SHOW. A write to the digit currently shown appears on `ascii_out` one cycle after the write edge, with no anode change.
- Slot counter: 20 bits, counting 0 to `SCAN_DIV-1`, then reset to 0. It does not free-run past the terminal count.
- Unused `an_n` combinations never occur. At most one bit of `an_n` is low in any cycle.

## Timing
- Reset values (applied immediately on `rst_n` low, independent of `clk`):
  - state = IDLE, idx = 0, counter = 0.
  - `an_n` = 4'b1111, `ascii_out` = 7'h20, `dp_out` = 0, `wr_ack` = 0, `frame_start` = 0.
  - All buffer entries = 8'h20.
- Reset asserted mid-frame blanks the display at once. After release, scanning restarts from digit 0 on the first edge with `en` = 1.
- Slot length is exactly `SCAN_DIV` cycles and frame length is exactly 4 × `SCAN_DIV` cycles. The `frame_start` period equals the frame length.
- Latency from `en` rising to the first anode-on is `1 + BLANK_CYC` cycles.
- Latency from `en` falling to all anodes off is 1 cycle.
- A write and an idx change on the same edge: `ascii_out` shows the new idx's buffer entry. If the write targets that idx, the new data appears one cycle later.

## Test plan
- Reset and defaults: hold `rst_n` low with random inputs. Require `an_n` = 1111, `ascii_out` = 20h, `dp_out` = 0, and `wr_ack` = `frame_start` = 0. Enable without any writes: every digit shows 20h.
- Scan sequence (`SCAN_DIV` = 10, `BLANK_CYC` = 2):
  - Stimulus: write "ABCD" to addresses 0–3, then raise `en`.
  - Digit 0 slot: 2 cycles of 1111, then 8 cycles of 1110 with `ascii_out` = 41h.
  - Digit 1 slot: 2 cycles of 1111, then 8 cycles of 1101 with 42h.
  - Then 1011 with 43h, then 0111 with 44h.
  - `frame_start` pulses exactly every 40 cycles.
- Decimal point and ack: write 8'hB1 to address 2. Require `wr_ack` high for exactly 1 cycle. During the digit 2 SHOW phase, require `ascii_out` = 31h and `dp_out` = 1.
- Live update: during digit 1's SHOW phase, write 8'h5A to address 1. Require `ascii_out` = 5Ah one cycle later, with `an_n` steady at 1101 and the slot timing unchanged.
- Disable and resume: drop `en` in the middle of digit 1's SHOW phase. Require `an_n` = 1111 and `ascii_out` = 20h on the next cycle. On re-enable, require `frame_start` and digit 0's BLANK phase, with the first anode-on 3 cycles after the `en` rising edge.
- Asynchronous reset mid-frame: assert `rst_n` low between clock edges during SHOW. Require outputs to take their reset values before the next edge. After release, all buffer entries must read back as 20h on the display.
